// File: rtl/arb_mux_n.sv
// Registered N:1 arbitrating mux with per-channel valid/ack, fixed or round-robin grant.
// Optional feature: define ARB_MUX_PARITY_EN to add the registered even-parity output OP.
module arb_mux_n #(
   parameter int unsigned WIDTH    = 16,
   parameter int unsigned CHANNELS = 4,
   parameter int unsigned SELW     = 2
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic [WIDTH*CHANNELS-1:0] D,
   input  logic [CHANNELS-1:0]       V,
   output logic [CHANNELS-1:0]       ACK,
   input  logic                      MODE,
   input  logic [SELW-1:0]           SEL,
   output logic [WIDTH-1:0]          O,
   output logic [SELW-1:0]           OCH,
   output logic                      OV,
   input  logic                      ORDY
`ifdef ARB_MUX_PARITY_EN
   ,
   output logic                      OP
`endif
);

   logic [WIDTH-1:0] o_q;
   logic [SELW-1:0]  och_q;
   logic             ov_q;
   logic [SELW-1:0]  ptr_q;

   logic             ld;
   logic             grant;
   logic [SELW-1:0]  gnt_idx;
   logic [WIDTH-1:0] word;
   int unsigned      cand_idx;

   // Output register is free, or its word is consumed on this edge.
   assign ld = !ov_q | ORDY;

   always_comb begin
      grant    = 1'b0;
      gnt_idx  = '0;
      word     = '0;
      cand_idx = 0;
      ACK      = '0;
      if (!RST && ld) begin
         if (!MODE) begin
            // Loop bound keeps SEL >= CHANNELS from ever matching.
            for (int unsigned j = 0; j < CHANNELS; j++) begin
               if (SEL == SELW'(j) && V[j]) begin
                  grant   = 1'b1;
                  gnt_idx = SELW'(j);
               end
            end
         end else begin
            // Scan PTR+1 .. PTR (mod CHANNELS); first valid wins.
            for (int unsigned i = 1; i <= CHANNELS; i++) begin
               cand_idx = (32'(ptr_q) + i) % CHANNELS;
               for (int unsigned j = 0; j < CHANNELS; j++) begin
                  if (!grant && cand_idx == j && V[j]) begin
                     grant   = 1'b1;
                     gnt_idx = SELW'(j);
                  end
               end
            end
         end
      end
      for (int unsigned j = 0; j < CHANNELS; j++) begin
         if (grant && gnt_idx == SELW'(j)) begin
            ACK[j] = 1'b1;
            word   = D[j*WIDTH +: WIDTH];
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         o_q   <= '0;
         och_q <= '0;
         ov_q  <= 1'b0;
         ptr_q <= SELW'(CHANNELS - 1);
      end else if (ld) begin
         if (grant) begin
            o_q   <= word;
            och_q <= gnt_idx;
            ov_q  <= 1'b1;
            if (MODE) begin
               ptr_q <= gnt_idx;
            end
         end else begin
            ov_q <= 1'b0;
         end
      end
   end

`ifdef ARB_MUX_PARITY_EN
   logic op_q;

   always_ff @(posedge CLK) begin
      if (RST) begin
         op_q <= 1'b0;
      end else if (ld && grant) begin
         op_q <= ^word;
      end
   end

   assign OP = op_q;
`endif

   assign O   = o_q;
   assign OCH = och_q;
   assign OV  = ov_q;

endmodule

// File: tb/tb_arb_mux_n.sv
// Directed bench for arb_mux_n: a 4-channel instance plus a 3-channel one for the SEL range edge.
module tb_arb_mux_n;

   logic        clk;
   logic        RST;
   logic [63:0] D;
   logic [3:0]  V;
   logic [3:0]  ACK;
   logic        MODE;
   logic [1:0]  SEL;
   logic [15:0] O;
   logic [1:0]  OCH;
   logic        OV;
   logic        ORDY;
   logic [2:0]  ack3;
   logic [15:0] o3;
   logic [1:0]  och3;
   logic        ov3;
`ifdef ARB_MUX_PARITY_EN
   logic        op;
   logic        op3;
`endif

   int n_pass;
   int n_total;

   arb_mux_n #(.WIDTH(16), .CHANNELS(4), .SELW(2)) u_dut (
      .CLK(clk), .RST(RST), .D(D), .V(V), .ACK(ACK), .MODE(MODE), .SEL(SEL),
      .O(O), .OCH(OCH), .OV(OV), .ORDY(ORDY)
`ifdef ARB_MUX_PARITY_EN
      , .OP(op)
`endif
   );

   arb_mux_n #(.WIDTH(16), .CHANNELS(3), .SELW(2)) u_dut3 (
      .CLK(clk), .RST(RST), .D(D[47:0]), .V(V[2:0]), .ACK(ack3), .MODE(MODE), .SEL(SEL),
      .O(o3), .OCH(och3), .OV(ov3), .ORDY(ORDY)
`ifdef ARB_MUX_PARITY_EN
      , .OP(op3)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Inputs change 1 time unit after the rising edge; checks run 2 units later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic do_reset();
      RST = 1'b1;
      tick();
      RST = 1'b0;
   endtask

   task automatic test_reset();
      RST = 1'b1; V = 4'b0000; MODE = 1'b0; SEL = 2'd0; ORDY = 1'b1; D = '0;
      tick(); settle();
      n_total++; if (O !== 16'h0000) $display("FAIL rst_o got=%h exp=0000", O); else n_pass++;
      n_total++; if (OCH !== 2'd0) $display("FAIL rst_och got=%0d exp=0", OCH); else n_pass++;
      n_total++; if (OV !== 1'b0) $display("FAIL rst_ov got=%b exp=0", OV); else n_pass++;
      n_total++; if (ACK !== 4'b0000) $display("FAIL rst_ack got=%b exp=0000", ACK); else n_pass++;
      V = 4'b1111; MODE = 1'b1; settle();
      n_total++; if (ACK !== 4'b0000) $display("FAIL rst_ack_v got=%b exp=0000", ACK); else n_pass++;
      tick(); settle();
      n_total++; if (OV !== 1'b0) $display("FAIL rst2_ov got=%b exp=0", OV); else n_pass++;
      n_total++; if (O !== 16'h0000) $display("FAIL rst2_o got=%h exp=0000", O); else n_pass++;
      RST = 1'b0; V = 4'b0000; settle();
      n_total++; if (ACK !== 4'b0000) $display("FAIL idle_ack got=%b exp=0000", ACK); else n_pass++;
      tick(); settle();
      n_total++; if (OV !== 1'b0) $display("FAIL idle_ov got=%b exp=0", OV); else n_pass++;
      n_total++; if (OCH !== 2'd0) $display("FAIL idle_och got=%0d exp=0", OCH); else n_pass++;
   endtask

   task automatic test_fixed();
      MODE = 1'b0; SEL = 2'd2; V = 4'b1111; ORDY = 1'b1;
      D = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
      settle();
      n_total++; if (ACK !== 4'b0100) $display("FAIL fix_ack got=%b exp=0100", ACK); else n_pass++;
      n_total++; if (ack3 !== 3'b100) $display("FAIL fix_ack3 got=%b exp=100", ack3); else n_pass++;
      tick(); settle();
      n_total++; if (O !== 16'h3333) $display("FAIL fix_o got=%h exp=3333", O); else n_pass++;
      n_total++; if (OCH !== 2'd2) $display("FAIL fix_och got=%0d exp=2", OCH); else n_pass++;
      n_total++; if (OV !== 1'b1) $display("FAIL fix_ov got=%b exp=1", OV); else n_pass++;
      n_total++; if (o3 !== 16'h3333) $display("FAIL fix_o3 got=%h exp=3333", o3); else n_pass++;
      SEL = 2'd3; settle();
      n_total++; if (ACK !== 4'b1000) $display("FAIL fix3_ack got=%b exp=1000", ACK); else n_pass++;
      n_total++; if (ack3 !== 3'b000) $display("FAIL oor_ack3 got=%b exp=000", ack3); else n_pass++;
      tick(); settle();
      n_total++; if (O !== 16'h4444) $display("FAIL fix3_o got=%h exp=4444", O); else n_pass++;
      n_total++; if (OCH !== 2'd3) $display("FAIL fix3_och got=%0d exp=3", OCH); else n_pass++;
      n_total++; if (ov3 !== 1'b0) $display("FAIL oor_ov3 got=%b exp=0", ov3); else n_pass++;
      n_total++; if (o3 !== 16'h3333) $display("FAIL oor_o3 got=%h exp=3333", o3); else n_pass++;
      n_total++; if (och3 !== 2'd2) $display("FAIL oor_och3 got=%0d exp=2", och3); else n_pass++;
   endtask

   task automatic test_rr_fair();
      logic [15:0] exp_o;
      logic [3:0]  exp_ack;
      V = 4'b0000;
      do_reset();
      MODE = 1'b1; V = 4'b1111; ORDY = 1'b1;
      D = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
      for (int i = 0; i < 8; i++) begin
         exp_ack = 4'b0001 << (i % 4);
         exp_o   = 16'h1111 * 16'(i % 4 + 1);
         settle();
         n_total++;
         if (ACK !== exp_ack) $display("FAIL rr_ack[%0d] got=%b exp=%b", i, ACK, exp_ack);
         else n_pass++;
         tick(); settle();
         n_total++;
         if (OCH !== 2'(i % 4)) $display("FAIL rr_och[%0d] got=%0d exp=%0d", i, OCH, i % 4);
         else n_pass++;
         n_total++;
         if (O !== exp_o || OV !== 1'b1)
            $display("FAIL rr_o[%0d] got=%h/%b exp=%h/1", i, O, OV, exp_o);
         else n_pass++;
         #1;
      end
   endtask

   task automatic test_rr_sparse();
      do_reset();
      MODE = 1'b1; ORDY = 1'b1; V = 4'b0010;
      tick();
      // PTR is now 1.
      V = 4'b1010; settle();
      n_total++; if (ACK !== 4'b1000) $display("FAIL sp_ack0 got=%b exp=1000", ACK); else n_pass++;
      tick(); settle();
      n_total++; if (OCH !== 2'd3) $display("FAIL sp_och0 got=%0d exp=3", OCH); else n_pass++;
      n_total++; if (ACK !== 4'b0010) $display("FAIL sp_ack1 got=%b exp=0010", ACK); else n_pass++;
      tick(); settle();
      n_total++; if (OCH !== 2'd1) $display("FAIL sp_och1 got=%0d exp=1", OCH); else n_pass++;
      n_total++; if (ACK !== 4'b1000) $display("FAIL sp_ack2 got=%b exp=1000", ACK); else n_pass++;
      tick(); settle();
      n_total++; if (OCH !== 2'd3) $display("FAIL sp_och2 got=%0d exp=3", OCH); else n_pass++;
      n_total++; if (O !== 16'h4444) $display("FAIL sp_o2 got=%h exp=4444", O); else n_pass++;
   endtask

   task automatic test_backpressure();
      // Holding ch3 with PTR=3 from the sparse test.
      V = 4'b1111; ORDY = 1'b0;
      for (int i = 0; i < 3; i++) begin
         settle();
         n_total++;
         if (ACK !== 4'b0000) $display("FAIL bp_ack[%0d] got=%b exp=0000", i, ACK);
         else n_pass++;
         n_total++;
         if (O !== 16'h4444 || OCH !== 2'd3 || OV !== 1'b1)
            $display("FAIL bp_hold[%0d] got=%h/%0d/%b exp=4444/3/1", i, O, OCH, OV);
         else n_pass++;
         tick();
      end
      ORDY = 1'b1; settle();
      n_total++; if (ACK !== 4'b0001) $display("FAIL bp_ack_rel got=%b exp=0001", ACK); else n_pass++;
      tick(); settle();
      n_total++;
      if (O !== 16'h1111 || OCH !== 2'd0 || OV !== 1'b1)
         $display("FAIL bp_drain got=%h/%0d/%b exp=1111/0/1", O, OCH, OV);
      else n_pass++;
      V = 4'b0000; tick(); settle();
      n_total++; if (OV !== 1'b0) $display("FAIL nogrant_ov got=%b exp=0", OV); else n_pass++;
      n_total++; if (O !== 16'h1111) $display("FAIL nogrant_o got=%h exp=1111", O); else n_pass++;
   endtask

   task automatic test_reset_mid();
      MODE = 1'b0; SEL = 2'd0; V = 4'b0001; ORDY = 1'b0;
      D = {16'h4444, 16'h3333, 16'h2222, 16'h00ff};
      tick(); settle();
      n_total++;
      if (O !== 16'h00ff || OV !== 1'b1) $display("FAIL mid_load got=%h/%b exp=00ff/1", O, OV);
      else n_pass++;
      RST = 1'b1; MODE = 1'b1; V = 4'b1111; ORDY = 1'b1; settle();
      n_total++; if (ACK !== 4'b0000) $display("FAIL mid_ack got=%b exp=0000", ACK); else n_pass++;
      tick(); RST = 1'b0; settle();
      n_total++; if (OV !== 1'b0) $display("FAIL mid_ov got=%b exp=0", OV); else n_pass++;
      n_total++; if (O !== 16'h0000) $display("FAIL mid_o got=%h exp=0000", O); else n_pass++;
      n_total++; if (ACK !== 4'b0001) $display("FAIL mid_rr0 got=%b exp=0001", ACK); else n_pass++;
      tick(); settle();
      n_total++; if (OCH !== 2'd0) $display("FAIL mid_och got=%0d exp=0", OCH); else n_pass++;
   endtask

`ifdef ARB_MUX_PARITY_EN
   task automatic test_parity();
      do_reset(); settle();
      n_total++; if (op !== 1'b0) $display("FAIL par_rst got=%b exp=0", op); else n_pass++;
      MODE = 1'b0; SEL = 2'd0; V = 4'b0001; ORDY = 1'b1;
      D = {16'h4444, 16'h3333, 16'h2222, 16'h0007};
      tick(); settle();
      n_total++; if (op !== 1'b1) $display("FAIL par_7 got=%b exp=1", op); else n_pass++;
      D = {16'h4444, 16'h3333, 16'h2222, 16'h0003};
      tick(); settle();
      n_total++; if (op !== 1'b0) $display("FAIL par_3 got=%b exp=0", op); else n_pass++;
   endtask
`endif

   initial begin
      n_pass  = 0;
      n_total = 0;
      RST = 1'b1; D = '0; V = '0; MODE = 1'b0; SEL = '0; ORDY = 1'b1;
      test_reset();
      test_fixed();
      test_rr_fair();
      test_rr_sparse();
      test_backpressure();
      test_reset_mid();
`ifdef ARB_MUX_PARITY_EN
      test_parity();
`endif
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/arb_mux_n.md
Name: arb_mux_n

Overview:
- Parametrised, registered N:1 datapath mux; successor to the fixed 16-bit 4:1 combinational mux.
- Adds per-channel valid/acknowledge handshaking, a registered output stage with valid/ready, and a selectable round-robin arbitration mode.
- Sits between multiple 16-bit producers (ALU result, memory read, immediate path, PC path) and a single consumer register or bus.

Parameters:
- WIDTH, 16, data width per channel in bits.
- CHANNELS, 4, number of input channels (2..16).
- SELW, 2, select/channel-id width in bits; must satisfy 2^SELW >= CHANNELS.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  synchronous reset, active-high.
- D  input  WIDTH*CHANNELS  packed channel data; channel k occupies D[k*WIDTH +: WIDTH].
- V  input  CHANNELS  per-channel valid.
- ACK  output  CHANNELS  per-channel accept, combinational, one-hot or zero.
- MODE  input  1  0 = fixed select, 1 = round-robin.
- SEL  input  SELW  channel select, used only when MODE=0.
- O  output  WIDTH  registered output data.
- OCH  output  SELW  registered id of the channel that produced O.
- OV  output  1  output valid.
- ORDY  input  1  consumer ready.

Behaviour:
- Reset (RST=1 at a rising edge):
  - O=0, OCH=0, OV=0, round-robin pointer PTR=CHANNELS-1.
  - ACK=0 throughout any cycle in which RST=1.
  - Reset overrides all other events, including an in-flight transfer; that data is dropped.
- Load enable: LD = !OV | ORDY. The output register is free, or is being drained this cycle.
- Grant selection (combinational, evaluated only when LD=1):
  - MODE=0: candidate c=SEL.
    - Grant only if SEL < CHANNELS and V[SEL]=1.
    - SEL >= CHANNELS never grants.
  - MODE=1: scan channels PTR+1, PTR+2, ..., wrapping modulo CHANNELS through PTR.
    - The first channel with V=1 is granted.
- On grant of channel c:
  - ACK[c]=1 in that same cycle.
  - At the next edge: O<=D[c], OCH<=c, OV<=1.
  - If MODE=1, also PTR<=c. In MODE=0, PTR is unchanged.
- LD=1 with no grant: at the next edge OV<=0; O and OCH hold their last values.
- LD=0 (OV=1, ORDY=0): ACK=0; O, OCH, OV and PTR all hold. Producers must keep V and D stable until acknowledged.
- Timing:
  - Latency from accept to OV is 1 cycle.
  - Sustained throughput is 1 word per cycle when ORDY is held at 1.
- Simultaneous drain and accept (OV=1, ORDY=1, grant): old word consumed and new word loaded on the same edge; OV stays 1.
- MODE or SEL changes take effect in the next arbitration cycle. A registered word is never altered by them.
- Fairness in MODE=1: with all V=1, grants cycle 0,1,...,CHANNELS-1,0. The first grant after reset is channel 0.
- ACK is never asserted for a channel whose V=0.
- ACK has at most one bit set per cycle.

Optional Feature:
- Macro ARB_MUX_PARITY_EN.
- Defined:
  - Adds output port OP (1 bit) = even parity (XOR reduction) of the word loaded into O.
  - OP is registered on the same edge as O and reset to 0.
- Undefined: port OP is absent; no parity logic.

Test Plan:
1. Reset then idle:
   - Stimulus: RST=1 for 2 cycles, then V=0.
   - Required: O=0x0000, OCH=0, OV=0, ACK=0 on every cycle.
2. Fixed select:
   - Stimulus: MODE=0, SEL=2, D ch0..3 = 0x1111/0x2222/0x3333/0x4444, V=4'b1111, ORDY=1.
   - Required: ACK=4'b0100; next cycle O=0x3333, OCH=2, OV=1.
   - Then SEL=3 (out of range when CHANNELS=3): no ACK, OV falls to 0.
3. Round-robin fairness:
   - Stimulus: MODE=1, all V=1, ORDY=1, 8 cycles after reset.
   - Required: OCH sequence 0,1,2,3,0,1,2,3 and O tracks the matching D.
4. Sparse round-robin:
   - Stimulus: V=4'b1010, PTR=1.
   - Required: grant ch3, then ch1, then ch3; ch0 and ch2 are never acknowledged.
5. Backpressure:
   - Stimulus: OV=1, ORDY=0 for 3 cycles with V=4'b1111.
   - Required: ACK=0, O/OCH stable for those 3 cycles; ORDY=1 then drains and loads the next grant on the same edge, with OV staying 1.
6. Reset mid-transfer and parity:
   - Stimulus: OV=1 with O=0x00FF, then RST=1.
   - Required: next cycle OV=0, O=0, PTR restarts so the next MODE=1 grant is ch0.
   - With ARB_MUX_PARITY_EN defined: loading 0x0007 gives OP=1, loading 0x0003 gives OP=0.
